// File: rtl/imm_extend_seq_if.sv
// Chunk-in / result-out handshake bundle for imm_extend_seq.
// The slave modport is the extender's view, the master modport is the source/consumer view.
interface imm_extend_seq_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
);
    localparam int MAXC = OUT_W / IN_W;
    localparam int CW   = $clog2(MAXC + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  I;
    logic             in_last;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] O;
    logic [CW-1:0]    count;
    logic             ovf;

    modport master (
        output in_valid, I, in_last, mode, out_ready,
        input  in_ready, out_valid, O, count, ovf
    );

    modport slave (
        input  in_valid, I, in_last, mode, out_ready,
        output in_ready, out_valid, O, count, ovf
    );
endinterface

// File: rtl/imm_extend_seq.sv
// Sequential immediate builder: MS-chunk-first accumulation, then zero/sign/upper extension.
// Optional feature macro IMM_EXT_SIGN_EN enables sign mode; without it mode 01 acts as zero mode.
module imm_extend_seq #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    imm_extend_seq_if.slave     bus
);
    localparam int MAXC = OUT_W / IN_W;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MAXC_N = CW'(MAXC);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [OUT_W-1:0] acc;
    logic [CW-1:0]    n;
    logic             ovf_r;
    logic [OUT_W-1:0] o_r;

    logic             accept;
    logic [OUT_W-1:0] acc_next;
    logic [CW-1:0]    n_next;
    logic             ovf_next;
    logic             upper_mode;
    logic             sign_mode;
    logic [OUT_W-1:0] result;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] v;

    assign bus.in_ready  = (state != HOLD);
    assign bus.out_valid = (state == HOLD);
    assign bus.O         = o_r;
    assign bus.count     = n;
    assign bus.ovf       = ovf_r;

    assign accept   = bus.in_valid && bus.in_ready;
    assign acc_next = {acc[OUT_W-IN_W-1:0], bus.I};
    assign n_next   = (n == MAXC_N) ? MAXC_N : n + CW'(1);
    assign ovf_next = ovf_r | (n == MAXC_N);

    assign upper_mode = (bus.mode == 2'b10);
`ifdef IMM_EXT_SIGN_EN
    assign sign_mode  = (bus.mode == 2'b01);
`else
    assign sign_mode  = 1'b0;
`endif

    // Extension is selected by the saturated chunk count; each count has a fixed field width.
    always_comb begin
        result = '0;
        mask   = '0;
        v      = '0;
        for (int j = 1; j <= MAXC; j++) begin
            if (n_next == CW'(j)) begin
                mask = {OUT_W{1'b1}} >> (OUT_W - j * IN_W);
                v    = acc_next & mask;
                if (upper_mode) begin
                    result = v << (OUT_W - j * IN_W);
                end else if (sign_mode && acc_next[j * IN_W - 1]) begin
                    result = v | ~mask;
                end else begin
                    result = v;
                end
            end
        end
    end

    // Result is captured on the last-chunk edge and held until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            n     <= '0;
            ovf_r <= 1'b0;
            o_r   <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= acc_next;
                        n     <= n_next;
                        ovf_r <= ovf_next;
                        if (bus.in_last) begin
                            o_r   <= result;
                            state <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        n     <= '0;
                        ovf_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_extend_seq.sv
// Scoreboard bench for imm_extend_seq (IN_W=4, OUT_W=16) with directed vectors.
module tb_imm_extend_seq;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [15:0] o;
        logic [2:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    imm_extend_seq_if #(.IN_W(4), .OUT_W(16)) bus ();

    imm_extend_seq #(.IN_W(4), .OUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change shortly after the rising edge so the negedge monitor never races the driver.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sendChunk(input logic [3:0] d, input logic last, input logic [1:0] m);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.I        = d;
        bus.in_last  = last;
        bus.mode     = m;
        while (!bus.in_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!bus.in_ready) checkOutput("in_ready_wait", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (bus.out_valid && guard < 20) begin
            step();
            guard++;
        end
        if (bus.out_valid) checkOutput("result_taken", 32'(bus.out_valid), 32'd0);
    endtask

    // Non-last chunks carry the inverted mode so mode is only honoured on the last chunk.
    task automatic applyStimulus(input logic [31:0] word, input int nc, input logic [1:0] m,
                                 input logic [15:0] exp_o, input logic [2:0] exp_cnt,
                                 input logic exp_ovf, input bit gap);
        logic [3:0] d;
        logic       last;
        sb.push_back('{exp_o, exp_cnt, exp_ovf});
        for (int c = 0; c < nc; c++) begin
            d    = word[(nc - 1 - c) * 4 +: 4];
            last = (c == nc - 1);
            sendChunk(d, last, last ? m : ~m);
            if (!last && gap) step();
        end
        checkOutput("latency_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
        waitIdle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 32'(bus.O), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                checkOutput("O", 32'(bus.O), 32'(e.o));
                checkOutput("count", 32'(bus.count), 32'(e.cnt));
                checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.I         = '0;
        bus.in_last   = 1'b0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        step();
        checkOutput("reset_O", 32'(bus.O), 32'd0);
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 16; i++)
            applyStimulus(32'(i), 1, 2'b00, 16'(i), 3'd1, 1'b0, 1'b0);

`ifdef IMM_EXT_SIGN_EN
        applyStimulus(32'hA,  1, 2'b01, 16'hFFFA, 3'd1, 1'b0, 1'b0);
        applyStimulus(32'h83, 2, 2'b01, 16'hFF83, 3'd2, 1'b0, 1'b1);
`else
        applyStimulus(32'hA,  1, 2'b01, 16'h000A, 3'd1, 1'b0, 1'b0);
        applyStimulus(32'h83, 2, 2'b01, 16'h0083, 3'd2, 1'b0, 1'b1);
`endif
        applyStimulus(32'h73,   2, 2'b01, 16'h0073, 3'd2, 1'b0, 1'b0);
        applyStimulus(32'hABCD, 4, 2'b01, 16'hABCD, 3'd4, 1'b0, 1'b0);
        applyStimulus(32'h5,    1, 2'b10, 16'h5000, 3'd1, 1'b0, 1'b0);
        applyStimulus(32'h12,   2, 2'b10, 16'h1200, 3'd2, 1'b0, 1'b0);
        applyStimulus(32'hC3,   2, 2'b00, 16'h00C3, 3'd2, 1'b0, 1'b0);
        applyStimulus(32'hF,    1, 2'b11, 16'h000F, 3'd1, 1'b0, 1'b0);
        applyStimulus(32'h12345, 5, 2'b00, 16'h2345, 3'd4, 1'b1, 1'b0);
        applyStimulus(32'h1,    1, 2'b00, 16'h0001, 3'd1, 1'b0, 1'b0);

        // Backpressure: result held while a new chunk waits at the input.
        bus.out_ready = 1'b0;
        sb.push_back('{16'h00B0, 3'd2, 1'b0});
        sendChunk(4'hB, 1'b0, 2'b10);
        sendChunk(4'h0, 1'b1, 2'b00);
        bus.in_valid = 1'b1;
        bus.I        = 4'h6;
        bus.in_last  = 1'b1;
        bus.mode     = 2'b00;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("bp_O_stable", 32'(bus.O), 32'h00B0);
            checkOutput("bp_count_stable", 32'(bus.count), 32'd2);
        end
        bus.out_ready = 1'b1;
        sb.push_back('{16'h0006, 3'd1, 1'b0});
        step();
        checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("bp_next_out_valid", 32'(bus.out_valid), 32'd1);
        waitIdle();

        // Reset in the middle of a three-chunk immediate.
        sendChunk(4'h4, 1'b0, 2'b00);
        sendChunk(4'h5, 1'b0, 2'b00);
        checkOutput("partial_count", 32'(bus.count), 32'd2);
        rst = 1'b1;
        #1;
        checkOutput("midrst_O", 32'(bus.O), 32'd0);
        checkOutput("midrst_count", 32'(bus.count), 32'd0);
        checkOutput("midrst_ovf", 32'(bus.ovf), 32'd0);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        applyStimulus(32'h9, 1, 2'b00, 16'h0009, 3'd1, 1'b0, 1'b0);

        step();
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
